// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue for a UART: edge-detects the receiver's done level, queues bytes
// with show-ahead read, sticky overflow and a saturating framing-error count.
// Optional macro UART_RX_FIFO_ERR_TAG_EN stores the error tag per entry and exposes rdErr.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rxDone,
    input  logic          rxErr,
    input  logic [7:0]    rxOut,
    input  logic          rdEn,
    input  logic          ovfClr,
    output logic [7:0]    rdData,
`ifdef UART_RX_FIFO_ERR_TAG_EN
    output logic          rdErr,
`endif
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    errCount
);

`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [AW:0]   count_nxt;
    logic          rx_done_p0;
    logic          push_evt;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_nxt;

    assign push_evt = rxDone & ~rx_done_p0;

`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign push_req = push_evt;
    assign wr_entry = {rxErr, rxOut};
`else
    // Errored bytes are counted but never enter the queue.
    assign push_req = push_evt & ~rxErr;
    assign wr_entry = rxOut;
`endif

    always_comb begin
        do_pop     = rdEn & ~empty;
        do_push    = push_req & (~full | do_pop);
        drop       = push_req & full & ~do_pop;
        rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
        count_nxt  = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // Bypass the array when the byte being written becomes the new head.
        if (do_push && (wr_ptr == rd_ptr_nxt))
            head_nxt = wr_entry;
        else
            head_nxt = mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_p0 <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            overflow   <= 1'b0;
            errCount   <= 8'h00;
            rdData     <= 8'h00;
`ifdef UART_RX_FIFO_ERR_TAG_EN
            rdErr      <= 1'b0;
`endif
        end else begin
            rx_done_p0 <= rxDone;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            empty  <= (count_nxt == '0);
            full   <= (count_nxt == FULL_CNT);
            if (drop)
                overflow <= 1'b1;
            else if (ovfClr)
                overflow <= 1'b0;
            if (push_evt && rxErr)
                errCount <= sat_inc8(errCount);
            if (count_nxt != '0) begin
`ifdef UART_RX_FIFO_ERR_TAG_EN
                {rdErr, rdData} <= head_nxt;
`else
                rdData <= head_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH=16): reset, edge-detected push, fill/overflow,
// full push+pop, error counting, mid-operation reset and reads while empty.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_out;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_count;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic       rd_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .rxDone   (rx_done),
        .rxErr    (rx_err),
        .rxOut    (rx_out),
        .rdEn     (rd_en),
        .ovfClr   (ovf_clr),
        .rdData   (rd_data),
`ifdef UART_RX_FIFO_ERR_TAG_EN
        .rdErr    (rd_err),
`endif
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .errCount (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic [7:0] b, input logic e);
        rx_out  = b;
        rx_err  = e;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rx_err  = 1'b0;
        tick();
    endtask

    task automatic pop_expect(input logic [7:0] exp, input string name);
        vectors++;
        if (rd_data !== exp) begin
            miscompares++;
            $display("FAIL %s: rdData got %h expected %h", name, rd_data, exp);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rx_done = 1'b1;
        apply_reset();
        vectors++;
        if ({count, empty, full, overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_flags: count/empty/full/ovf got %0d/%b/%b/%b expected 0/1/0/0",
                     count, empty, full, overflow);
        end
        vectors++;
        if ({err_count, rd_data} !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_data: errCount/rdData got %h/%h expected 00/00", err_count, rd_data);
        end
        repeat (3) tick();
        vectors++;
        if (count !== 5'd0) begin
            miscompares++;
            $display("FAIL held_done_no_push: count got %0d expected 0", count);
        end
        rx_done = 1'b0;
        tick();
        rx_out  = 8'h3C;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL push_after_low: count/rdData got %0d/%h expected 1/3c", count, rd_data);
        end
    endtask

    task automatic test_single_push();
        apply_reset();
        rx_out  = 8'h55;
        rx_err  = 1'b0;
        rx_done = 1'b1;
        tick();
        vectors++;
        if (count !== 5'd1 || empty !== 1'b0 || rd_data !== 8'h55) begin
            miscompares++;
            $display("FAIL first_push: count/empty/rdData got %0d/%b/%h expected 1/0/55",
                     count, empty, rd_data);
        end
        repeat (9) tick();
        vectors++;
        if (count !== 5'd1) begin
            miscompares++;
            $display("FAIL level_one_push: count got %0d expected 1", count);
        end
        rx_done = 1'b0;
        tick();
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b0);
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL filled: full/ovf/count got %b/%b/%0d expected 1/0/16", full, overflow, count);
        end
        push(8'hAA, 1'b0);
        vectors++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL overflow: full/ovf/count got %b/%b/%0d expected 1/1/16", full, overflow, count);
        end
        // Drop coinciding with a clear: overflow must stay set.
        rx_out  = 8'hCC;
        rx_done = 1'b1;
        ovf_clr = 1'b1;
        tick();
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL set_wins: overflow got %b expected 1", overflow);
        end
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || count !== 5'd16) begin
            miscompares++;
            $display("FAIL ovf_clear: overflow/count got %b/%0d expected 0/16", overflow, count);
        end
        for (int i = 1; i <= 16; i++) pop_expect(8'(i), "fill_order");
        vectors++;
        if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL drained: empty/count/full got %b/%0d/%b expected 1/0/0", empty, count, full);
        end
    endtask

    task automatic test_full_push_pop();
        apply_reset();
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b0);
        vectors++;
        if (rd_data !== 8'h01) begin
            miscompares++;
            $display("FAIL full_head: rdData got %h expected 01", rd_data);
        end
        rx_out  = 8'hBB;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        vectors++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_pushpop: count/ovf/full got %0d/%b/%b expected 16/0/1",
                     count, overflow, full);
        end
        for (int i = 2; i <= 16; i++) pop_expect(8'(i), "after_pushpop");
        pop_expect(8'hBB, "bb_last");
        vectors++;
        if (empty !== 1'b1) begin
            miscompares++;
            $display("FAIL bb_drained: empty got %b expected 1", empty);
        end
    endtask

    task automatic test_err_count();
        apply_reset();
        push(8'h33, 1'b1);
        vectors++;
        if (err_count !== 8'd1) begin
            miscompares++;
            $display("FAIL err_count1: errCount got %0d expected 1", err_count);
        end
`ifdef UART_RX_FIFO_ERR_TAG_EN
        vectors++;
        if (count !== 5'd1 || rd_err !== 1'b1 || rd_data !== 8'h33) begin
            miscompares++;
            $display("FAIL err_tagged: count/rdErr/rdData got %0d/%b/%h expected 1/1/33",
                     count, rd_err, rd_data);
        end
`else
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL err_dropped: count/empty got %0d/%b expected 0/1", count, empty);
        end
`endif
        for (int i = 0; i < 254; i++) push(8'h44, 1'b1);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL err_255: errCount got %0d expected 255", err_count);
        end
        push(8'h45, 1'b1);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL err_saturate: errCount got %0d expected 255", err_count);
        end
`ifndef UART_RX_FIFO_ERR_TAG_EN
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL err_no_ovf: overflow got %b expected 0", overflow);
        end
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        #4;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: count/empty got %0d/%b expected 0/1", count, empty);
        end
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        tick();
        push(8'h77, 1'b0);
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'h77) begin
            miscompares++;
            $display("FAIL post_reset_push: count/rdData got %0d/%h expected 1/77", count, rd_data);
        end
    endtask

    task automatic test_empty_read();
        apply_reset();
        rd_en = 1'b1;
        repeat (5) tick();
        rd_en = 1'b0;
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL empty_rd: count/empty got %0d/%b expected 0/1", count, empty);
        end
        push(8'h5A, 1'b0);
        push(8'h5B, 1'b0);
        vectors++;
        if (count !== 5'd2) begin
            miscompares++;
            $display("FAIL empty_rd_count: count got %0d expected 2", count);
        end
        pop_expect(8'h5A, "empty_rd_first");
        pop_expect(8'h5B, "empty_rd_second");
        vectors++;
        if (empty !== 1'b1 || rd_data !== 8'h5B) begin
            miscompares++;
            $display("FAIL empty_hold: empty/rdData got %b/%h expected 1/5b", empty, rd_data);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        push(8'hA1, 1'b0);
        // Pop and push together on a non-empty queue; then on an empty queue.
        rx_out  = 8'hA2;
        rx_done = 1'b1;
        rd_en   = 1'b1;
        tick();
        rx_done = 1'b0;
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'hA2) begin
            miscompares++;
            $display("FAIL pushpop_nonempty: count/rdData got %0d/%h expected 1/a2", count, rd_data);
        end
        tick();
        vectors++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL pop_to_empty: count/empty got %0d/%b expected 0/1", count, empty);
        end
        rx_out  = 8'hA3;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
        rd_en   = 1'b0;
        vectors++;
        if (count !== 5'd1 || rd_data !== 8'hA3) begin
            miscompares++;
            $display("FAIL pushpop_empty: count/rdData got %0d/%h expected 1/a3", count, rd_data);
        end
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_done = 1'b0;
        rx_err  = 1'b0;
        rx_out  = 8'h00;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_full_push_pop();
        test_err_count();
        test_reset_mid();
        test_empty_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, 4..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL be rising-edge.
REQ-004 reset  input  1  reset; asynchronous, active-low.
REQ-005 rxDone  input  1  receiver byte-complete flag; a level the receiver may hold high for many cycles.
REQ-006 rxErr  input  1  receiver framing-error flag; qualified by the rxDone rising edge.
REQ-007 rxOut  input  8  received byte; qualified by the rxDone rising edge.
REQ-008 rdEn  input  1  consumer pop request.
REQ-009 ovfClr  input  1  clears the overflow flag.
REQ-010 rdData  output  8  head-of-queue byte, show-ahead.
REQ-011 empty  output  1  queue holds zero entries.
REQ-012 full  output  1  queue holds DEPTH entries.
REQ-013 count  output  AW+1  current occupancy, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag: a byte was dropped because the queue was full.
REQ-015 errCount  output  8  count of framing-errored bytes; saturates at 255.

Function
REQ-016 Push event: registered copy of rxDone is low and current rxDone is high; exactly one push per rising edge, however long rxDone stays high.
- rxDone high during reset release: SHALL NOT push until rxDone has been seen low.
REQ-017 Push writes {rxOut} at the write pointer; the byte is visible on rdData one cycle after the push edge if the queue was empty.
REQ-018 Pop event: rdEn high and empty low; advances the read pointer; the next entry appears on rdData the following cycle.
REQ-019 rdEn while empty: ignored; no pointer or count change.
REQ-020 Push and pop in the same cycle, not empty: both occur; count unchanged.
REQ-021 Push and pop in the same cycle, empty: pop ignored, push occurs; count becomes 1.
REQ-022 Push and pop in the same cycle, full: both occur; no overflow.
REQ-023 Push while full without pop: byte dropped; overflow set at the next edge; pointers and count unchanged.
REQ-024 overflow stays set until ovfClr is high at an edge; a drop in the same cycle as ovfClr SHALL leave overflow set (set wins).
REQ-025 Pointers: AW bits, wrap modulo DEPTH.
REQ-026 Flag derivation from count: empty = (count==0), full = (count==DEPTH); flags and count registered, no combinational path from rdEn.
REQ-027 Each push with rxErr high increments errCount, saturating at 255.
REQ-028 rdData when empty: holds the last value presented; content is don't-care.

Reset
REQ-029 Reset low SHALL asynchronously clear: pointers, count=0, empty=1, full=0, overflow=0, errCount=0, rdData=8'h00, and the rxDone edge register.
- The edge register SHALL clear to 1, so a held rxDone does not push (per REQ-016).
REQ-030 Reset mid-operation discards all queued bytes; storage array contents need not be cleared.

Configuration
REQ-031 Macro UART_RX_FIFO_ERR_TAG_EN.
- Defined: each entry is 9 bits {rxErr, rxOut}; extra output port rdErr (1 bit) shows the head entry's error tag alongside rdData; errored bytes are queued.
- Undefined: rdErr port absent; bytes with rxErr high SHALL NOT be pushed (still counted by errCount, never cause overflow).

Verification
REQ-032 Reset, then rxDone rising with rxOut=8'h55, rxErr=0, held high 10 cycles -> count=1 (exactly one push), empty=0, rdData=8'h55 one cycle after the edge.
REQ-033 Push 8'h01..8'h10 (16 bytes), then a 17th byte 8'hAA -> full=1, overflow=1, count=16; pop 16 -> bytes 8'h01..8'h10 in order, then empty=1.
REQ-034 With count=16, push 8'hBB and rdEn in the same cycle -> count stays 16, overflow=0, 8'hBB read last.
REQ-035 Push with rxOut=8'h33, rxErr=1 -> errCount=1.
- With the macro: count=1, rdErr=1.
- Without the macro: count=0, empty=1.
REQ-036 Push 3 bytes, assert reset low mid-cycle for 2 cycles -> immediately count=0, empty=1; a push after release lands at rdData with count=1.
REQ-037 rdEn held high 5 cycles while empty -> count=0, no pointer movement; the next push reads back correctly.
